// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: result select, write commit, two read ports and a retired-write counter.
// Optional macro WB_BYPASS_EN forwards the committing value to the read ports during the commit cycle.
`timescale 1ns/1ps
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_mem_wb,
  input  logic              MemtoReg_mem_wb,
  input  logic [DATA_W-1:0] read_data_mem_wb,
  input  logic [DATA_W-1:0] result_mem_wb,
  input  logic [ADDR_W-1:0] Reg_dest_op_mem_wb,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] rs_raw;
  logic [DATA_W-1:0] rt_raw;

  assign wb_data  = MemtoReg_mem_wb ? read_data_mem_wb : result_mem_wb;
  assign wb_we    = regwrite_mem_wb && (Reg_dest_op_mem_wb != '0);
  assign wb_count = count_q;

  // Register 0 is excluded through wb_we, so it keeps its reset value forever.
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    if (wb_we) begin
      regs_d[Reg_dest_op_mem_wb] = wb_data;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q  <= '{default: '0};
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  // Reset gating keeps the bypass path from leaking wb_data while the file is held clear.
  always_comb begin
    rs_raw = regs_q[rs_addr];
    rt_raw = regs_q[rt_addr];
`ifdef WB_BYPASS_EN
    if (wb_we && (rs_addr == Reg_dest_op_mem_wb)) rs_raw = wb_data;
    if (wb_we && (rt_addr == Reg_dest_op_mem_wb)) rt_raw = wb_data;
`endif
    rs_data = (!reset || (rs_addr == '0)) ? '0 : rs_raw;
    rt_data = (!reset || (rt_addr == '0)) ? '0 : rt_raw;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a negedge monitor pops and compares them.
// Build with WB_BYPASS_EN defined to check the same-cycle bypass expectations.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regwrite_mem_wb = 1'b0;
  logic        MemtoReg_mem_wb = 1'b0;
  logic [31:0] read_data_mem_wb = '0;
  logic [31:0] result_mem_wb = '0;
  logic [4:0]  Reg_dest_op_mem_wb = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] wb_count;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int SEL_RS  = 0;
  localparam int SEL_RT  = 1;
  localparam int SEL_WBD = 2;
  localparam int SEL_WE  = 3;
  localparam int SEL_CNT = 4;

  typedef struct {
    int          id;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   next_id = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .regwrite_mem_wb    (regwrite_mem_wb),
    .MemtoReg_mem_wb    (MemtoReg_mem_wb),
    .read_data_mem_wb   (read_data_mem_wb),
    .result_mem_wb      (result_mem_wb),
    .Reg_dest_op_mem_wb (Reg_dest_op_mem_wb),
    .rs_addr            (rs_addr),
    .rt_addr            (rt_addr),
    .rs_data            (rs_data),
    .rt_data            (rt_data),
    .wb_data            (wb_data),
    .wb_we              (wb_we),
    .wb_count           (wb_count)
  );

  always #5 clk = ~clk;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_RS:  return "rs_data";
      SEL_RT:  return "rt_data";
      SEL_WBD: return "wb_data";
      SEL_WE:  return "wb_we";
      default: return "wb_count";
    endcase
  endfunction

  // Monitor: mid-cycle, every queued expectation is checked against the live outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RS:  act = rs_data;
        SEL_RT:  act = rt_data;
        SEL_WBD: act = wb_data;
        SEL_WE:  act = {31'b0, wb_we};
        default: act = wb_count;
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("[TB] FAIL check%0d %s got=%h want=%h", e.id, sel_name(e.sel), act, e.val);
      end
    end
  end

  task automatic applyStimulus(input logic rw, input logic m2r, input logic [31:0] rd,
                               input logic [31:0] res, input logic [4:0] dest,
                               input logic [4:0] rs, input logic [4:0] rt);
    regwrite_mem_wb    = rw;
    MemtoReg_mem_wb    = m2r;
    read_data_mem_wb   = rd;
    result_mem_wb      = res;
    Reg_dest_op_mem_wb = dest;
    rs_addr            = rs;
    rt_addr            = rt;
  endtask

  task automatic checkOutput(input int sel, input logic [31:0] val);
    exp_t e;
    e.id  = next_id;
    e.sel = sel;
    e.val = val;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    $display("[TB] start, bypass=%0d", BYPASS);

    // Held in reset: outputs combinational, reads forced to zero, nothing commits.
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0000_0042, 5'd5, 5'd5, 5'd5);
    checkOutput(SEL_WE, 32'd1);
    checkOutput(SEL_WBD, 32'h0000_0042);
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_RT, 32'h0);
    tick();
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_CNT, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      checkOutput(SEL_RS, 32'h0);
      checkOutput(SEL_RT, 32'h0);
      tick();
    end
    checkOutput(SEL_CNT, 32'h0);

    // ALU result to r3, then load data to r7.
    applyStimulus(1'b1, 1'b0, 32'h1111_1111, 32'h0000_00A5, 5'd3, 5'd3, 5'd0);
    checkOutput(SEL_WBD, 32'h0000_00A5);
    checkOutput(SEL_WE, 32'd1);
    checkOutput(SEL_RS, BYPASS ? 32'h0000_00A5 : 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    checkOutput(SEL_RS, 32'h0000_00A5);
    checkOutput(SEL_CNT, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h2222_2222, 5'd7, 5'd0, 5'd7);
    checkOutput(SEL_WBD, 32'hDEAD_BEEF);
    checkOutput(SEL_RT, BYPASS ? 32'hDEAD_BEEF : 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
    checkOutput(SEL_RT, 32'hDEAD_BEEF);
    checkOutput(SEL_RS, 32'h0000_00A5);
    checkOutput(SEL_CNT, 32'd2);
    tick();

    // Destination 0 is not a write and is not counted.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    checkOutput(SEL_WE, 32'd0);
    checkOutput(SEL_WBD, 32'hFFFF_FFFF);
    checkOutput(SEL_RS, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_CNT, 32'd2);
    tick();

    // Read and write r9 in the same cycle on both ports.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd9, 5'd9, 5'd9);
    checkOutput(SEL_RS, BYPASS ? 32'h1234_5678 : 32'h0);
    checkOutput(SEL_RT, BYPASS ? 32'h1234_5678 : 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    checkOutput(SEL_RS, 32'h1234_5678);
    checkOutput(SEL_RT, 32'h1234_5678);
    checkOutput(SEL_CNT, 32'd3);
    tick();

    // regwrite low with an unknown select must leave r4 alone.
    applyStimulus(1'b0, 1'bx, 32'h6666_6666, 32'h5555_5555, 5'd4, 5'd4, 5'd3);
    checkOutput(SEL_WE, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_RT, 32'h0000_00A5);
    checkOutput(SEL_CNT, 32'd3);
    tick();

    // r12 written, then reset drops mid-cycle while another r12 write is in flight.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'hCAFE_0001, 5'd12, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd12);
    checkOutput(SEL_RS, 32'hCAFE_0001);
    checkOutput(SEL_CNT, 32'd4);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0BAD_0BAD, 5'd12, 5'd12, 5'd12);
    #1;
    reset = 1'b0;
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_RT, 32'h0);
    checkOutput(SEL_CNT, 32'h0);
    checkOutput(SEL_WE, 32'd1);
    checkOutput(SEL_WBD, 32'h0BAD_0BAD);
    tick();
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_CNT, 32'h0);
    tick();

    // Release reset: nothing committed during reset, first edge after release accepts a write.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd7);
    reset = 1'b1;
    checkOutput(SEL_RS, 32'h0);
    checkOutput(SEL_RT, 32'h0);
    checkOutput(SEL_CNT, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0077, 32'h0, 5'd12, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd7);
    checkOutput(SEL_RS, 32'h0000_0077);
    checkOutput(SEL_RT, 32'h0);
    checkOutput(SEL_CNT, 32'd1);
    tick();

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      tick();
      waited++;
    end
    if (sb.size() > 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
